// File: rtl/parity_mem_scrub.sv
// Parity-protected single-port memory with valid tracking,
// read-side parity check, saturating error counter and clear sweep.
module parity_mem_scrub #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int PARITY_ODD = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write,
  input  logic                 read,
  input  logic [ADDR_W-1:0]    address,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 inject_err,
  input  logic                 clear_req,
  output logic [DATA_W:0]      data_out,
  output logic                 rd_valid,
  output logic                 par_err,
  output logic                 uninit,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int   DEPTH = 1 << ADDR_W;
  localparam logic POL   = (PARITY_ODD != 0);

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e               state_q;
  logic [ADDR_W-1:0]    ptr_q;
  logic [DEPTH-1:0]     valid_q;
  logic [DATA_W:0]      data_out_q;
  logic                 rd_valid_q;
  logic                 par_err_q;
  logic                 uninit_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_d;
  logic                 busy_q;

  logic [DATA_W:0]      mem_q [DEPTH];

  logic                 idle;
  logic                 start;
  logic                 wr_en;
  logic                 rd_en;
  logic [DATA_W:0]      rd_word;
  logic                 rd_hit;
  logic                 rd_bad;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [DATA_W:0]      mem_wdata;

  assign idle    = (state_q == IDLE);
  assign start   = idle & clear_req;
  assign wr_en   = idle & write & ~clear_req;
  assign rd_en   = idle & read & ~write & ~clear_req;
  assign rd_word = mem_q[address];
  assign rd_hit  = valid_q[address];
  assign rd_bad  = ((^rd_word[DATA_W-1:0]) ^ POL) != rd_word[DATA_W];

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (start)
      err_cnt_d = '0;
    else if (rd_en && rd_hit && rd_bad && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  // The sweep owns the single write port while it runs.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = address;
    mem_wdata = {(^data_in) ^ POL ^ inject_err, data_in};
    unique case (1'b1)
      (state_q == SWEEP): begin
        mem_we    = 1'b1;
        mem_addr  = ptr_q;
        mem_wdata = {POL, {DATA_W{1'b0}}};
      end
      default: mem_we = wr_en;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem_q[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      valid_q    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      uninit_q   <= 1'b0;
      err_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      err_cnt_q  <= err_cnt_d;
      if (rd_en) begin
        data_out_q <= rd_hit ? rd_word : '0;
        par_err_q  <= rd_hit & rd_bad;
        uninit_q   <= ~rd_hit;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end else if (wr_en) begin
            valid_q[address] <= 1'b1;
          end
        end
        SWEEP: begin
          valid_q[ptr_q] <= 1'b1;
          ptr_q          <= ptr_q + 1'b1;
          if (&ptr_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign par_err   = par_err_q;
  assign uninit    = uninit_q;
  assign err_count = err_cnt_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_parity_mem_scrub.sv
// Scoreboard bench for parity_mem_scrub; a second instance with a
// 2-bit error counter shares the stimulus to exercise saturation.
module tb_parity_mem_scrub;

  logic       clk;
  logic       rst_n;
  logic       write;
  logic       read;
  logic [3:0] address;
  logic [7:0] data_in;
  logic       inject_err;
  logic       clear_req;

  logic [8:0] data_out;
  logic       rd_valid;
  logic       par_err;
  logic       uninit;
  logic [7:0] err_count;
  logic       busy;

  logic [8:0] s_data_out;
  logic       s_rd_valid;
  logic       s_par_err;
  logic       s_uninit;
  logic [1:0] s_err_count;
  logic       s_busy;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       un;
  } exp_t;

  exp_t sbq[$];
  int   checks;
  int   failures;

  parity_mem_scrub #(
    .DATA_W(8), .ADDR_W(4), .PARITY_ODD(0), .ERR_CNT_W(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .write(write), .read(read),
    .address(address), .data_in(data_in), .inject_err(inject_err),
    .clear_req(clear_req), .data_out(data_out), .rd_valid(rd_valid),
    .par_err(par_err), .uninit(uninit), .err_count(err_count),
    .busy(busy)
  );

  parity_mem_scrub #(
    .DATA_W(8), .ADDR_W(4), .PARITY_ODD(0), .ERR_CNT_W(2)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .write(write), .read(read),
    .address(address), .data_in(data_in), .inject_err(inject_err),
    .clear_req(clear_req), .data_out(s_data_out),
    .rd_valid(s_rd_valid), .par_err(s_par_err), .uninit(s_uninit),
    .err_count(s_err_count), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL rd_valid unexpected: data_out=%h pe=%b un=%b",
                 data_out, par_err, uninit);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (data_out !== e.d || par_err !== e.pe || uninit !== e.un) begin
          failures++;
          $display("FAIL rd_data: got %h/%b/%b exp %h/%b/%b",
                   data_out, par_err, uninit, e.d, e.pe, e.un);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic w, input logic r, input logic c,
                       input logic inj, input logic [3:0] a,
                       input logic [7:0] d);
    write      = w;
    read       = r;
    clear_req  = c;
    inject_err = inj;
    address    = a;
    data_in    = d;
    @(posedge clk);
    #1;
    write      = 1'b0;
    read       = 1'b0;
    clear_req  = 1'b0;
    inject_err = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d,
                    input logic inj);
    issue(1'b1, 1'b0, 1'b0, inj, a, d);
  endtask

  task automatic rd(input logic [3:0] a, input logic [8:0] d,
                    input logic pe, input logic un);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.un = un;
    sbq.push_back(e);
    issue(1'b0, 1'b1, 1'b0, 1'b0, a, 8'h00);
  endtask

  task automatic drain(input string tag);
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s drain: pending=%0d exp 0", tag, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (data_out !== 9'h000) begin
      failures++;
      $display("FAIL reset data_out: got %h exp 000", data_out);
    end
    checks++;
    if (rd_valid !== 1'b0 || par_err !== 1'b0 || uninit !== 1'b0) begin
      failures++;
      $display("FAIL reset flags: got %b%b%b exp 000",
               rd_valid, par_err, uninit);
    end
    checks++;
    if (err_count !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset cnt/busy: got %0d/%b exp 0/0", err_count, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(4'd3, 9'h000, 1'b0, 1'b1);
    drain("reset_read");
  endtask

  task automatic test_rw;
    wr(4'd5, 8'h07, 1'b0);
    rd(4'd5, 9'h107, 1'b0, 1'b0);
    wr(4'd6, 8'h03, 1'b0);
    rd(4'd6, 9'h003, 1'b0, 1'b0);
    wr(4'd15, 8'hFF, 1'b0);
    rd(4'd15, 9'h0FF, 1'b0, 1'b0);
    rd(4'd0, 9'h000, 1'b0, 1'b1);
    drain("rw");
    checks++;
    if (err_count !== 8'd0) begin
      failures++;
      $display("FAIL rw err_count: got %0d exp 0", err_count);
    end
  endtask

  task automatic test_inject;
    wr(4'd5, 8'h07, 1'b1);
    for (int i = 0; i < 3; i++) rd(4'd5, 9'h007, 1'b1, 1'b0);
    drain("inject3");
    checks++;
    if (err_count !== 8'd3) begin
      failures++;
      $display("FAIL inject err_count: got %0d exp 3", err_count);
    end
    for (int i = 0; i < 2; i++) rd(4'd5, 9'h007, 1'b1, 1'b0);
    drain("inject5");
    checks++;
    if (err_count !== 8'd5) begin
      failures++;
      $display("FAIL inject err_count5: got %0d exp 5", err_count);
    end
    checks++;
    if (s_err_count !== 2'd3) begin
      failures++;
      $display("FAIL sat err_count: got %0d exp 3", s_err_count);
    end
    rd(4'd6, 9'h003, 1'b0, 1'b0);
    drain("inject_clean");
    checks++;
    if (par_err !== 1'b0 || err_count !== 8'd5) begin
      failures++;
      $display("FAIL clean read: pe=%b cnt=%0d exp 0/5", par_err, err_count);
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 8'hAA);
    drain("wr_rd_same");
    rd(4'd2, 9'h0AA, 1'b0, 1'b0);
    wr(4'd2, 8'h01, 1'b0);
    rd(4'd2, 9'h101, 1'b0, 1'b0);
    drain("b2b");
  endtask

  task automatic test_sweep;
    int cnt;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 8'h55);
    cnt = 0;
    read    = 1'b1;
    address = 4'd5;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else break;
      address = address + 4'd1;
    end
    read = 1'b0;
    checks++;
    if (cnt != 16) begin
      failures++;
      $display("FAIL sweep busy_cycles: got %0d exp 16", cnt);
    end
    checks++;
    if (err_count !== 8'd0 || s_err_count !== 2'd0) begin
      failures++;
      $display("FAIL sweep err_count: got %0d/%0d exp 0/0",
               err_count, s_err_count);
    end
    drain("sweep_busy_reads");
    for (int a = 0; a < 16; a++) rd(4'(a), 9'h000, 1'b0, 1'b0);
    drain("sweep_readback");
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 8'h00);
    repeat (6) @(posedge clk);
    #3;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midsweep busy: got %b exp 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL async reset busy: got %b exp 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(4'd2, 9'h000, 1'b0, 1'b1);
    rd(4'd12, 9'h000, 1'b0, 1'b1);
    drain("reset_mid");
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = '0;
    data_in    = '0;
    inject_err = 1'b0;
    clear_req  = 1'b0;
    test_reset();
    test_rw();
    test_inject();
    test_back_to_back();
    test_sweep();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
